// File: rtl/voxel_projector.sv
// Orthographic voxel-grid renderer: scans an N^3 colour grid along one axis per
// screen pixel and writes the first non-empty voxel (or background) to the framebuffer.
module voxel_projector #(
  parameter int N_LOG2 = 3,
  parameter int COLOR_W = 8,
  parameter int ADDR_W = 12,
  parameter int PITCH_LOG2 = 5,
  parameter logic [COLOR_W-1:0] BG_COLOR = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  display_on,
  input  logic [8:0]            hpos,
  input  logic [8:0]            vpos,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  dir,
  input  logic [ADDR_W-1:0]     base,
  input  logic                  vox_we,
  input  logic [3*N_LOG2-1:0]   vox_addr,
  input  logic [COLOR_W-1:0]    vox_data,
  output logic                  busy,
  output logic                  done,
  output logic                  we,
  output logic [ADDR_W-1:0]     addr,
  output logic [COLOR_W-1:0]    ram_d
);

  localparam int VA_W = 3 * N_LOG2;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, FINISH} state_t;

  state_t               state;
  logic [N_LOG2-1:0]    u, v, d;
  logic [N_LOG2-1:0]    x, y, z;
  logic [1:0]           mode_q;
  logic                 dir_q;
  logic [ADDR_W-1:0]    base_q;
  logic [COLOR_W-1:0]   color;
  logic [COLOR_W-1:0]   voxel;
  logic [ADDR_W-1:0]    pix_addr;
  logic                 last_d;
  logic [N_LOG2-1:0]    first_d;

  logic [COLOR_W-1:0]   vox_mem [0:(1<<VA_W)-1];

  // Beam position is reserved for future raster-synchronous modes.
  logic unused_beam;
  assign unused_beam = ^{hpos, vpos};

  always_ff @(posedge clk) begin
    if (vox_we && !busy)
      vox_mem[vox_addr] <= vox_data;
  end

  always_comb begin
    x = u;
    y = v;
    z = d;
    case (mode_q)
      2'd1: begin x = u; y = d; z = v; end
      2'd2: begin x = d; y = u; z = v; end
      default: begin x = u; y = v; z = d; end
    endcase
  end

  assign voxel    = vox_mem[{x, y, z}];
  assign last_d   = dir_q ? (d == '0) : (d == '1);
  assign first_d  = dir_q ? '1 : '0;
  assign pix_addr = base_q + (ADDR_W'(v) << PITCH_LOG2) + ADDR_W'(u);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      we     <= 1'b0;
      addr   <= '0;
      ram_d  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      u      <= '0;
      v      <= '0;
      d      <= '0;
      mode_q <= '0;
      dir_q  <= 1'b0;
      base_q <= '0;
      color  <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            dir_q  <= dir;
            base_q <= base;
            u      <= '0;
            v      <= '0;
            d      <= dir ? '1 : '0;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (voxel != '0) begin
            color <= voxel;
            state <= WRITE;
          end else if (last_d) begin
            color <= BG_COLOR;
            state <= WRITE;
          end else begin
            d <= dir_q ? d - 1'b1 : d + 1'b1;
          end
        end
        WRITE: begin
          // Stall here while video is active; the scan result stays latched.
          if (!display_on) begin
            we    <= 1'b1;
            addr  <= pix_addr;
            ram_d <= color;
            d     <= first_d;
            if (u == '1) begin
              u <= '0;
              if (v == '1) begin
                state <= FINISH;
              end else begin
                v     <= v + 1'b1;
                state <= SCAN;
              end
            end else begin
              u     <= u + 1'b1;
              state <= SCAN;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voxel_projector.sv
// Scoreboard bench for voxel_projector: a reference projector predicts every
// framebuffer write and the frame latency; captured writes are checked against it.
module tb_voxel_projector;

  logic        clk = 1'b0;
  logic        reset, display_on, start, dir, vox_we;
  logic [8:0]  hpos, vpos;
  logic [1:0]  mode;
  logic [11:0] base;
  logic [8:0]  vox_addr;
  logic [7:0]  vox_data;
  logic        busy, done, we;
  logic [11:0] addr;
  logic [7:0]  ram_d;

  always #5 clk = ~clk;

  voxel_projector dut (
    .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .start(start), .mode(mode), .dir(dir), .base(base), .vox_we(vox_we),
    .vox_addr(vox_addr), .vox_data(vox_data), .busy(busy), .done(done),
    .we(we), .addr(addr), .ram_d(ram_d)
  );

  int          compared = 0;
  int          mismatched = 0;
  int          viol = 0;
  logic [7:0]  vmodel [512];
  logic [19:0] exp_q [$];
  logic [19:0] wr_log [$];
  logic [19:0] e, g;

  // One clock: sample outputs at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (we) begin
      wr_log.push_back({addr, ram_d});
      if (display_on) viol++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_pix(input int m, input bit dr, input int pu, input int pv,
                                         output int cost);
    int dd, x, y, z;
    for (int k = 0; k < 8; k++) begin
      dd = dr ? 7 - k : k;
      case (m)
        1: begin x = pu; y = dd; z = pv; end
        2: begin x = dd; y = pu; z = pv; end
        default: begin x = pu; y = pv; z = dd; end
      endcase
      if (vmodel[x*64 + y*8 + z] != 8'h00) begin
        cost = k + 1;
        return vmodel[x*64 + y*8 + z];
      end
    end
    cost = 8;
    return 8'h00;
  endfunction

  function automatic int count_hits(output logic [19:0] last);
    int n = 0;
    last = '0;
    foreach (wr_log[i]) if (wr_log[i][7:0] != 8'h00) begin n++; last = wr_log[i]; end
    return n;
  endfunction

  task automatic write_vox(input int x, input int y, input int z, input logic [7:0] c);
    vox_addr = 9'(x*64 + y*8 + z);
    vox_data = c;
    vox_we   = 1'b1;
    tick();
    vox_we   = 1'b0;
    vmodel[x*64 + y*8 + z] = c;
  endtask

  // Pushes the predicted writes, then pulses start across one rising edge.
  task automatic start_frame(input logic [1:0] m, input logic dr, input logic [11:0] b,
                             output int exp_lat);
    int cost;
    logic [7:0]  c;
    logic [11:0] a;
    exp_lat = 1;
    for (int pv = 0; pv < 8; pv++)
      for (int pu = 0; pu < 8; pu++) begin
        c = ref_pix(int'(m), dr, pu, pv, cost);
        exp_lat += cost + 1;
        a = b + 12'(pv*32 + pu);
        exp_q.push_back({a, c});
      end
    mode = m; dir = dr; base = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < budget);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({busy, done, we, addr, ram_d} !== 23'h0) begin
      mismatched++;
      $display("FAIL reset_state got busy=%b done=%b we=%b addr=%h ram_d=%h required all 0",
               busy, done, we, addr, ram_d);
    end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 512; i++) write_vox(i / 64, (i / 8) % 8, i % 8, 8'h00);
  endtask

  task automatic test_empty();
    int el, lat;
    start_frame(2'd0, 1'b0, 12'h000, el);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL busy_after_start got %b required 1", busy); end
    wait_done(2000, lat);
    $display("frame empty mode0 lat=%0d", lat);
    compared++;
    if (lat != 577) begin mismatched++; $display("FAIL empty_latency got %0d required 577", lat); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL busy_at_done got %b required 0", busy); end
    tick();
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL done_pulse_width got done=%b busy=%b required 0/0", done, busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); compared++;
      if (wr_log.size() == 0) begin
        mismatched++; $display("FAIL empty_write missing required %h/%h", e[19:8], e[7:0]);
      end else begin
        g = wr_log.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL empty_write got %h/%h required %h/%h", g[19:8], g[7:0], e[19:8], e[7:0]); end
      end
    end
    compared++;
    if (wr_log.size() != 0) begin mismatched++; $display("FAIL empty_extra_writes got %0d required 0", wr_log.size()); end
    wr_log.delete();
  endtask

  task automatic test_single_hit();
    int el, lat, n;
    logic [19:0] last;
    logic [11:0] want [4];
    want[0] = 12'd98; want[1] = 12'd162; want[2] = 12'd163; want[3] = 12'd98;
    write_vox(2, 3, 5, 8'hA5);
    for (int m = 0; m < 4; m++) begin
      start_frame(2'(m), 1'b0, 12'h000, el);
      wait_done(2000, lat);
      $display("frame single_hit mode%0d lat=%0d", m, lat);
      compared++;
      if (lat != el) begin mismatched++; $display("FAIL hit_latency mode%0d got %0d required %0d", m, lat, el); end
      if (m == 0) begin
        compared++;
        if (lat != 575) begin mismatched++; $display("FAIL hit_latency_mode0 got %0d required 575", lat); end
      end
      n = count_hits(last);
      compared++;
      if (n != 1 || last !== {want[m], 8'hA5}) begin
        mismatched++; $display("FAIL hit_pixel mode%0d got n=%0d %h/%h required 1 %h/a5", m, n, last[19:8], last[7:0], want[m]);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); compared++;
        if (wr_log.size() == 0) begin
          mismatched++; $display("FAIL hit_write missing required %h/%h", e[19:8], e[7:0]);
        end else begin
          g = wr_log.pop_front();
          if (g !== e) begin mismatched++; $display("FAIL hit_write got %h/%h required %h/%h", g[19:8], g[7:0], e[19:8], e[7:0]); end
        end
      end
      compared++;
      if (wr_log.size() != 0) begin mismatched++; $display("FAIL hit_extra_writes got %0d required 0", wr_log.size()); end
      wr_log.delete();
    end
  endtask

  task automatic test_display_stall();
    int el, lat, ph, cd;
    logic [19:0] last;
    viol = 0; ph = 0; cd = 0; lat = 0;
    start_frame(2'd0, 1'b0, 12'h000, el);
    // Raise display_on just before a WRITE-state edge so every high cycle is a stall.
    do begin
      tick();
      lat++;
      if (ph == 0 && wr_log.size() >= 3) begin ph = 1; cd = 7; end
      else if (ph == 1) begin cd--; if (cd == 0) begin display_on = 1'b1; ph = 2; cd = 100; end end
      else if (ph == 2) begin cd--; if (cd == 0) begin display_on = 1'b0; ph = 3; end end
    end while (!done && lat < 3000);
    display_on = 1'b0;
    $display("frame stall mode0 lat=%0d", lat);
    compared++;
    if (lat != el + 100 || lat != 675) begin mismatched++; $display("FAIL stall_latency got %0d required 675", lat); end
    compared++;
    if (viol != 0) begin mismatched++; $display("FAIL we_during_display got %0d required 0", viol); end
    compared++;
    if (count_hits(last) != 1 || last !== {12'd98, 8'hA5}) begin
      mismatched++; $display("FAIL stall_hit got %h/%h required 062/a5", last[19:8], last[7:0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); compared++;
      if (wr_log.size() == 0) begin
        mismatched++; $display("FAIL stall_write missing required %h/%h", e[19:8], e[7:0]);
      end else begin
        g = wr_log.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL stall_write got %h/%h required %h/%h", g[19:8], g[7:0], e[19:8], e[7:0]); end
      end
    end
    compared++;
    if (wr_log.size() != 0) begin mismatched++; $display("FAIL stall_extra_writes got %0d required 0", wr_log.size()); end
    wr_log.delete();
  endtask

  task automatic test_base_wrap();
    int el, lat;
    write_vox(2, 3, 5, 8'h00);
    start_frame(2'd0, 1'b0, 12'hFF0, el);
    wait_done(2000, lat);
    $display("frame base_wrap base=ff0 lat=%0d", lat);
    compared++;
    if (wr_log.size() < 9) begin
      mismatched++; $display("FAIL wrap_count got %0d required 64", wr_log.size());
    end else if (wr_log[0][19:8] !== 12'hFF0 || wr_log[8][19:8] !== 12'h010) begin
      mismatched++; $display("FAIL wrap_addr got %h,%h required ff0,010", wr_log[0][19:8], wr_log[8][19:8]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); compared++;
      if (wr_log.size() == 0) begin
        mismatched++; $display("FAIL wrap_write missing required %h/%h", e[19:8], e[7:0]);
      end else begin
        g = wr_log.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL wrap_write got %h/%h required %h/%h", g[19:8], g[7:0], e[19:8], e[7:0]); end
      end
    end
    compared++;
    if (wr_log.size() != 0) begin mismatched++; $display("FAIL wrap_extra_writes got %0d required 0", wr_log.size()); end
    wr_log.delete();
  endtask

  task automatic test_depth_order();
    int el, lat;
    logic [19:0] last;
    logic [7:0]  want;
    write_vox(1, 1, 2, 8'h11);
    write_vox(1, 1, 6, 8'h66);
    for (int dr = 0; dr < 2; dr++) begin
      want = (dr == 0) ? 8'h11 : 8'h66;
      start_frame(2'd0, dr[0], 12'h000, el);
      wait_done(2000, lat);
      $display("frame depth dir%0d lat=%0d", dr, lat);
      compared++;
      if (lat != el) begin mismatched++; $display("FAIL depth_latency dir%0d got %0d required %0d", dr, lat, el); end
      compared++;
      if (count_hits(last) != 1 || last !== {12'd33, want}) begin
        mismatched++; $display("FAIL depth_hit dir%0d got %h/%h required 021/%h", dr, last[19:8], last[7:0], want);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); compared++;
        if (wr_log.size() == 0) begin
          mismatched++; $display("FAIL depth_write missing required %h/%h", e[19:8], e[7:0]);
        end else begin
          g = wr_log.pop_front();
          if (g !== e) begin mismatched++; $display("FAIL depth_write got %h/%h required %h/%h", g[19:8], g[7:0], e[19:8], e[7:0]); end
        end
      end
      compared++;
      if (wr_log.size() != 0) begin mismatched++; $display("FAIL depth_extra_writes got %0d required 0", wr_log.size()); end
      wr_log.delete();
    end
  endtask

  task automatic test_reset_midframe();
    int el, lat, pre;
    logic [19:0] last;
    mode = 2'd0; dir = 1'b0; base = 12'h000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    #1;
    compared++;
    if ({busy, done, we, addr, ram_d} !== 23'h0) begin
      mismatched++; $display("FAIL midframe_reset got busy=%b done=%b we=%b addr=%h ram_d=%h required all 0",
                             busy, done, we, addr, ram_d);
    end
    wr_log.delete();
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    compared++;
    if (wr_log.size() != 0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL post_reset_idle got writes=%0d busy=%b required 0/0", wr_log.size(), busy);
    end
    wr_log.delete();
    start_frame(2'd0, 1'b0, 12'h000, el);
    pre = 0;
    repeat (30) begin
      tick();
      pre++;
      if (pre == 20) begin
        vox_addr = 9'(7*64 + 7*8 + 0); vox_data = 8'h77; vox_we = 1'b1;
        mode = 2'd2; dir = 1'b1; base = 12'h800; start = 1'b1;
      end else if (pre == 21) begin
        vox_we = 1'b0; start = 1'b0;
      end
    end
    wait_done(2000, lat);
    lat += pre;
    $display("frame after_reset lat=%0d", lat);
    compared++;
    if (lat != el) begin mismatched++; $display("FAIL after_reset_latency got %0d required %0d", lat, el); end
    compared++;
    if (count_hits(last) != 1 || last !== {12'd33, 8'h11}) begin
      mismatched++; $display("FAIL retained_voxel got %h/%h required 021/11", last[19:8], last[7:0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); compared++;
      if (wr_log.size() == 0) begin
        mismatched++; $display("FAIL after_reset_write missing required %h/%h", e[19:8], e[7:0]);
      end else begin
        g = wr_log.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL after_reset_write got %h/%h required %h/%h", g[19:8], g[7:0], e[19:8], e[7:0]); end
      end
    end
    compared++;
    if (wr_log.size() != 0) begin mismatched++; $display("FAIL after_reset_extra_writes got %0d required 0", wr_log.size()); end
    wr_log.delete();
  endtask

  initial begin
    reset = 1'b1; display_on = 1'b0; start = 1'b0; mode = 2'd0; dir = 1'b0; base = 12'h000;
    vox_we = 1'b0; vox_addr = '0; vox_data = '0; hpos = '0; vpos = '0;
    for (int i = 0; i < 512; i++) vmodel[i] = 8'h00;
    test_reset();
    test_empty();
    test_single_hit();
    test_display_stall();
    test_base_wrap();
    test_depth_order();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
